// File: rtl/cml_line_sched.sv
// cml_line_sched: Camera Link line scheduler that reads two ping-pong line
// buffers and produces the FVAL/LVAL/DVAL framing for the CML transmitter.
//
// Ports:
//   clk_user      sole clock
//   rst_n         asynchronous active-low reset
//   enable        frame-start permission, sampled only in IDLE
//   line_rdy[1:0] buffer b holds at least COL words
//   empty[1:0]    buffer b FWFT empty flag
//   rd_en[1:0]    read strobe to buffer b (combinational)
//   buf_sel       buffer currently owned by the scheduler
//   fval/lval/dval registered frame/line/data valid, aligned to FWFT data
//   frame_done    pulse on the first vertical-blank cycle
//   underflow     pulse on each stalled ACTIVE cycle
//   underflow_cnt saturating underflow count (CML_UNDERFLOW_CNT_EN only)
//
// Optional feature macro: CML_UNDERFLOW_CNT_EN

module cml_line_sched #(
    parameter int COL      = 1280,
    parameter int ROW      = 1024,
    parameter int HBLANK   = 16,
    parameter int VBLANK   = 64,
    parameter int FV_SETUP = 4
) (
    input  logic        clk_user,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  line_rdy,
    input  logic [1:0]  empty,
    output logic [1:0]  rd_en,
    output logic        buf_sel,
    output logic        fval,
    output logic        lval,
    output logic        dval,
    output logic        frame_done,
    output logic        underflow
`ifdef CML_UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_cnt
`endif
);

    localparam int CW   = (COL > 1) ? $clog2(COL) : 1;
    localparam int RW   = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int TMX1 = (HBLANK > VBLANK) ? HBLANK : VBLANK;
    localparam int TMAX = (TMX1 > FV_SETUP) ? TMX1 : FV_SETUP;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
    localparam logic [TW-1:0] S_LAST   = TW'(FV_SETUP - 1);
    localparam logic [TW-1:0] H_LAST   = TW'(HBLANK - 1);
    localparam logic [TW-1:0] V_LAST   = TW'(VBLANK - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_LINE,
        ACTIVE,
        HBLK,
        VBLK
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] col, col_nx;
    logic [RW-1:0] row, row_nx;
    logic [TW-1:0] tmr, tmr_nx;
    logic          buf_nx;
    logic          cur_empty;
    logic          cur_rdy;

    assign cur_empty = empty[buf_sel];
    assign cur_rdy   = line_rdy[buf_sel];

    always_ff @(posedge clk_user or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            col     <= '0;
            row     <= '0;
            tmr     <= '0;
            buf_sel <= 1'b0;
        end else begin
            state   <= state_nx;
            col     <= col_nx;
            row     <= row_nx;
            tmr     <= tmr_nx;
            buf_sel <= buf_nx;
        end
    end

    // tmr counts cycles spent in the timed states and restarts on exit.
    always_comb begin
        state_nx   = state;
        col_nx     = col;
        row_nx     = row;
        buf_nx     = buf_sel;
        tmr_nx     = tmr + TW'(1);
        rd_en      = 2'b00;
        underflow  = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                buf_nx = 1'b0;
                row_nx = '0;
                col_nx = '0;
                tmr_nx = '0;
                if (enable && line_rdy[0]) begin
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (tmr == S_LAST) begin
                    tmr_nx   = '0;
                    state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                tmr_nx = '0;
                if (cur_empty) begin
                    // stall: lval stays high, no read issued
                    underflow = 1'b1;
                end else begin
                    rd_en[buf_sel] = 1'b1;
                    if (col == COL_LAST) begin
                        col_nx = '0;
                        buf_nx = ~buf_sel;
                        if (row == ROW_LAST) begin
                            row_nx   = '0;
                            state_nx = VBLK;
                        end else begin
                            row_nx   = row + RW'(1);
                            state_nx = HBLK;
                        end
                    end else begin
                        col_nx = col + CW'(1);
                    end
                end
            end
            HBLK: begin
                if (tmr == H_LAST) begin
                    tmr_nx   = '0;
                    state_nx = cur_rdy ? ACTIVE : WAIT_LINE;
                end
            end
            WAIT_LINE: begin
                tmr_nx = '0;
                if (cur_rdy) begin
                    state_nx = ACTIVE;
                end
            end
            VBLK: begin
                frame_done = (tmr == '0);
                if (tmr == V_LAST) begin
                    tmr_nx   = '0;
                    buf_nx   = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Framing lags the state by one cycle to line up with FWFT read data.
    always_ff @(posedge clk_user or negedge rst_n) begin
        if (!rst_n) begin
            fval <= 1'b0;
            lval <= 1'b0;
            dval <= 1'b0;
        end else begin
            fval <= (state == SETUP) || (state == WAIT_LINE) ||
                    (state == ACTIVE) || (state == HBLK);
            lval <= (state == ACTIVE);
            dval <= |rd_en;
        end
    end

`ifdef CML_UNDERFLOW_CNT_EN
    always_ff @(posedge clk_user or negedge rst_n) begin
        if (!rst_n) begin
            underflow_cnt <= '0;
        end else if (underflow && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`endif

endmodule
